// File: rtl/mem_arbiter_pkg.sv
// Shared cache definitions: request/response structs and arbiter FSM states.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;

  // Encoding of the last_gnt bit
  localparam logic GNT_SRC_I = 1'b0;
  localparam logic GNT_SRC_D = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] w_data;
    logic              w_en;
    logic              req;
  } type_cache2mem_s;

  typedef struct packed {
    logic [LINE_W-1:0] r_data;
    logic              ack;
  } type_mem2cache_s;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } type_mem_arb_states_e;

  function automatic type_mem_arb_states_e grant_state(input logic src);
    return (src == GNT_SRC_D) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache links and the shared memory link seen by the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  type_cache2mem_s icache2mem_i;
  type_mem2cache_s mem2icache_o;
  type_cache2mem_s dcache2mem_i;
  type_mem2cache_s mem2dcache_o;
  type_cache2mem_s arb2mem_o;
  type_mem2cache_s mem2arb_i;

  modport slave (
    input  icache2mem_i,
    input  dcache2mem_i,
    input  mem2arb_i,
    output mem2icache_o,
    output mem2dcache_o,
    output arb2mem_o
  );

  modport master (
    output icache2mem_i,
    output dcache2mem_i,
    output mem2arb_i,
    input  mem2icache_o,
    input  mem2dcache_o,
    input  arb2mem_o
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-way round-robin arbiter between icache and dcache for one shared memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic DCACHE_PRIO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          arb_busy_o
);

  type_mem_arb_states_e state, state_nxt;
  logic                 last_gnt, last_gnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= ~DCACHE_PRIO;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    last_gnt_nxt      = last_gnt;
    bus.arb2mem_o     = '0;
    bus.mem2icache_o  = '0;
    bus.mem2dcache_o  = '0;
    arb_busy_o        = 1'b0;

    // Outputs are forced quiet while reset is held, even if a grant is in flight
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.icache2mem_i.req && bus.dcache2mem_i.req) begin
            last_gnt_nxt = ~last_gnt;
            state_nxt    = grant_state(~last_gnt);
          end else if (bus.icache2mem_i.req) begin
            last_gnt_nxt = GNT_SRC_I;
            state_nxt    = GNT_I;
          end else if (bus.dcache2mem_i.req) begin
            last_gnt_nxt = GNT_SRC_D;
            state_nxt    = GNT_D;
          end
        end
        GNT_I: begin
          arb_busy_o       = 1'b1;
          bus.arb2mem_o    = bus.icache2mem_i;
          bus.mem2icache_o = bus.mem2arb_i;
          if (bus.mem2arb_i.ack) state_nxt = RELEASE;
        end
        GNT_D: begin
          arb_busy_o       = 1'b1;
          bus.arb2mem_o    = bus.dcache2mem_i;
          bus.mem2dcache_o = bus.mem2arb_i;
          if (bus.mem2arb_i.ack) state_nxt = RELEASE;
        end
        RELEASE: begin
          // One cycle with memory req low so the memory cannot re-ack
          arb_busy_o = 1'b1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized run against a reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arb_busy_o;
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.DCACHE_PRIO(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .arb_busy_o (arb_busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic type_cache2mem_s rand_req();
    type_cache2mem_s r;
    r.addr   = $urandom();
    r.w_data = rand_line();
    r.w_en   = 1'($urandom_range(0, 1));
    r.req    = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.icache2mem_i = '0;
    bus.dcache2mem_i = '0;
    bus.mem2arb_i    = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.icache2mem_i = rand_req();
    bus.dcache2mem_i = rand_req();
    bus.mem2arb_i    = '{r_data: rand_line(), ack: 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.arb2mem_o !== '0) begin failures++; $display("FAIL rst_arb2mem got=%h exp=0", bus.arb2mem_o); end
      checks++; if (bus.mem2icache_o !== '0) begin failures++; $display("FAIL rst_mem2icache got=%h exp=0", bus.mem2icache_o); end
      checks++; if (bus.mem2dcache_o !== '0) begin failures++; $display("FAIL rst_mem2dcache got=%h exp=0", bus.mem2dcache_o); end
      checks++; if (arb_busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", arb_busy_o); end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL post_rst_state got=%0d exp=%0d", dut.state, IDLE); end
    checks++; if (dut.last_gnt !== 1'b0) begin failures++; $display("FAIL post_rst_last_gnt got=%b exp=0", dut.last_gnt); end
    checks++; if (bus.arb2mem_o !== '0) begin failures++; $display("FAIL post_rst_arb2mem got=%h exp=0", bus.arb2mem_o); end
    checks++; if (bus.mem2icache_o !== '0 || bus.mem2dcache_o !== '0) begin failures++; $display("FAIL post_rst_resp got=%h/%h exp=0/0", bus.mem2icache_o, bus.mem2dcache_o); end
    checks++; if (arb_busy_o !== 1'b0) begin failures++; $display("FAIL post_rst_busy got=%b exp=0", arb_busy_o); end
    tick();
    clear_inputs();
  endtask

  task automatic test_icache_read();
    type_cache2mem_s ic;
    logic [LINE_W-1:0] rd;
    type_mem2cache_s exp_i;
    reset_dut();
    ic = '{addr: 32'h100, w_data: rand_line(), w_en: 1'b0, req: 1'b1};
    rd = rand_line();
    bus.icache2mem_i = ic;
    @(negedge clk);
    checks++; if (dut.state !== IDLE || bus.arb2mem_o !== '0) begin failures++; $display("FAIL icr_first_cycle got=%0d/%h exp=%0d/0", dut.state, bus.arb2mem_o, IDLE); end
    tick();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) bus.mem2arb_i = '{r_data: rd, ack: 1'b1};
      exp_i = (k == 5) ? '{r_data: rd, ack: 1'b1} : '0;
      @(negedge clk);
      checks++; if (dut.state !== GNT_I) begin failures++; $display("FAIL icr_state_%0d got=%0d exp=%0d", k, dut.state, GNT_I); end
      checks++; if (bus.arb2mem_o !== ic) begin failures++; $display("FAIL icr_arb2mem_%0d got=%h exp=%h", k, bus.arb2mem_o, ic); end
      checks++; if (bus.mem2icache_o !== exp_i) begin failures++; $display("FAIL icr_resp_%0d got=%h exp=%h", k, bus.mem2icache_o, exp_i); end
      checks++; if (bus.mem2dcache_o !== '0) begin failures++; $display("FAIL icr_dresp_%0d got=%h exp=0", k, bus.mem2dcache_o); end
      checks++; if (arb_busy_o !== 1'b1) begin failures++; $display("FAIL icr_busy_%0d got=%b exp=1", k, arb_busy_o); end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    checks++; if (dut.state !== RELEASE) begin failures++; $display("FAIL icr_release got=%0d exp=%0d", dut.state, RELEASE); end
    checks++; if (bus.arb2mem_o !== '0 || arb_busy_o !== 1'b1) begin failures++; $display("FAIL icr_release_out got=%h/%b exp=0/1", bus.arb2mem_o, arb_busy_o); end
    tick();
    @(negedge clk);
    checks++; if (dut.state !== IDLE || arb_busy_o !== 1'b0) begin failures++; $display("FAIL icr_idle got=%0d/%b exp=%0d/0", dut.state, arb_busy_o, IDLE); end
    tick();
  endtask

  task automatic test_contention();
    type_cache2mem_s ic, dc;
    logic [LINE_W-1:0] rd;
    reset_dut();
    ic = rand_req();
    dc = rand_req();
    bus.icache2mem_i = ic;
    bus.dcache2mem_i = dc;
    tick();
    rd = rand_line();
    bus.mem2arb_i = '{r_data: rd, ack: 1'b1};
    @(negedge clk);
    checks++; if (dut.state !== GNT_D || dut.last_gnt !== 1'b1) begin failures++; $display("FAIL cont_first got=%0d/%b exp=%0d/1", dut.state, dut.last_gnt, GNT_D); end
    checks++; if (bus.arb2mem_o !== dc) begin failures++; $display("FAIL cont_arb_d got=%h exp=%h", bus.arb2mem_o, dc); end
    checks++; if (bus.mem2dcache_o !== {rd, 1'b1} || bus.mem2icache_o !== '0) begin failures++; $display("FAIL cont_resp_d got=%h/%h exp=%h/0", bus.mem2dcache_o, bus.mem2icache_o, {rd, 1'b1}); end
    tick();
    bus.mem2arb_i    = '0;
    bus.dcache2mem_i = '0;
    @(negedge clk);
    checks++; if (dut.state !== RELEASE) begin failures++; $display("FAIL cont_release got=%0d exp=%0d", dut.state, RELEASE); end
    tick();
    @(negedge clk);
    checks++; if (dut.state !== IDLE || bus.arb2mem_o !== '0) begin failures++; $display("FAIL cont_idle got=%0d/%h exp=%0d/0", dut.state, bus.arb2mem_o, IDLE); end
    tick();
    rd = rand_line();
    bus.mem2arb_i = '{r_data: rd, ack: 1'b1};
    @(negedge clk);
    checks++; if (dut.state !== GNT_I || dut.last_gnt !== 1'b0) begin failures++; $display("FAIL cont_second got=%0d/%b exp=%0d/0", dut.state, dut.last_gnt, GNT_I); end
    checks++; if (bus.arb2mem_o !== ic) begin failures++; $display("FAIL cont_arb_i got=%h exp=%h", bus.arb2mem_o, ic); end
    checks++; if (bus.mem2icache_o !== {rd, 1'b1} || bus.mem2dcache_o !== '0) begin failures++; $display("FAIL cont_resp_i got=%h/%h exp=%h/0", bus.mem2icache_o, bus.mem2dcache_o, {rd, 1'b1}); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    type_mem_arb_states_e exp_st;
    type_mem2cache_s mr;
    int acks_i = 0;
    int acks_d = 0;
    reset_dut();
    bus.icache2mem_i = rand_req();
    bus.dcache2mem_i = rand_req();
    for (int tx = 0; tx < 4; tx++) begin
      tick();
      exp_st = (tx % 2 == 0) ? GNT_D : GNT_I;
      mr = '{r_data: rand_line(), ack: 1'b1};
      bus.mem2arb_i = mr;
      @(negedge clk);
      if (bus.mem2icache_o.ack === 1'b1) acks_i++;
      if (bus.mem2dcache_o.ack === 1'b1) acks_d++;
      checks++; if (dut.state !== exp_st) begin failures++; $display("FAIL b2b_order_%0d got=%0d exp=%0d", tx, dut.state, exp_st); end
      checks++;
      if ((exp_st == GNT_D && (bus.mem2dcache_o !== mr || bus.mem2icache_o !== '0)) ||
          (exp_st == GNT_I && (bus.mem2icache_o !== mr || bus.mem2dcache_o !== '0))) begin
        failures++; $display("FAIL b2b_resp_%0d got=%h/%h exp_owner=%0d data=%h", tx, bus.mem2icache_o, bus.mem2dcache_o, exp_st, mr);
      end
      tick();
      bus.mem2arb_i = '0;
      @(negedge clk);
      if (bus.mem2icache_o.ack === 1'b1) acks_i++;
      if (bus.mem2dcache_o.ack === 1'b1) acks_d++;
      checks++; if (dut.state !== RELEASE || bus.arb2mem_o.req !== 1'b0) begin failures++; $display("FAIL b2b_release_%0d got=%0d/%b exp=%0d/0", tx, dut.state, bus.arb2mem_o.req, RELEASE); end
      tick();
    end
    checks++; if (acks_i != 2 || acks_d != 2) begin failures++; $display("FAIL b2b_ack_count got=%0d/%0d exp=2/2", acks_i, acks_d); end
    clear_inputs();
  endtask

  task automatic test_dcache_write();
    type_cache2mem_s dc;
    reset_dut();
    dc = '{addr: 32'h40, w_data: 128'hDEADBEEF_0123_4567_89AB_CDEF_0011_2233, w_en: 1'b1, req: 1'b1};
    bus.dcache2mem_i = dc;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (dut.state !== GNT_D) begin failures++; $display("FAIL wr_state_%0d got=%0d exp=%0d", k, dut.state, GNT_D); end
      checks++; if (bus.arb2mem_o !== dc) begin failures++; $display("FAIL wr_arb2mem_%0d got=%h exp=%h", k, bus.arb2mem_o, dc); end
      tick();
    end
    bus.mem2arb_i = '{r_data: '0, ack: 1'b1};
    @(negedge clk);
    checks++; if (bus.mem2dcache_o.ack !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b exp=1", bus.mem2dcache_o.ack); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    bus.icache2mem_i = rand_req();
    tick();
    tick();
    @(negedge clk);
    checks++; if (dut.state !== GNT_I) begin failures++; $display("FAIL midrst_pre got=%0d exp=%0d", dut.state, GNT_I); end
    tick();
    rst = 1'b1;
    bus.mem2arb_i = '{r_data: rand_line(), ack: 1'b1};
    @(negedge clk);
    checks++; if (bus.mem2icache_o !== '0 || bus.arb2mem_o !== '0 || arb_busy_o !== 1'b0) begin failures++; $display("FAIL midrst_during got=%h/%h/%b exp=0/0/0", bus.mem2icache_o, bus.arb2mem_o, arb_busy_o); end
    tick();
    rst = 1'b0;
    bus.mem2arb_i = '0;
    @(negedge clk);
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL midrst_state got=%0d exp=%0d", dut.state, IDLE); end
    checks++; if (bus.mem2icache_o !== '0 || bus.mem2dcache_o !== '0 || bus.arb2mem_o !== '0 || arb_busy_o !== 1'b0) begin failures++; $display("FAIL midrst_after got=%h/%h/%h/%b exp=0", bus.mem2icache_o, bus.mem2dcache_o, bus.arb2mem_o, arb_busy_o); end
    tick();
    clear_inputs();
  endtask

  task automatic test_spurious_ack();
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      bus.mem2arb_i = '{r_data: rand_line(), ack: 1'b1};
      @(negedge clk);
      checks++; if (bus.mem2icache_o !== '0 || bus.mem2dcache_o !== '0) begin failures++; $display("FAIL spur_resp_%0d got=%h/%h exp=0/0", k, bus.mem2icache_o, bus.mem2dcache_o); end
      checks++; if (dut.state !== IDLE || arb_busy_o !== 1'b0) begin failures++; $display("FAIL spur_state_%0d got=%0d/%b exp=%0d/0", k, dut.state, arb_busy_o, IDLE); end
      tick();
    end
    clear_inputs();
  endtask

  // Reference model: who owns the memory, whether the post-transaction gap is running,
  // and who was served most recently (1 = icache, 2 = dcache).
  task automatic test_random();
    type_cache2mem_s ic_req, dc_req, exp_arb;
    type_mem2cache_s exp_i, exp_d;
    logic exp_busy;
    bit   ic_pend = 0;
    bit   dc_pend = 0;
    int   owner = 0;
    bit   gap = 0;
    int   served_last = 1;
    reset_dut();
    ic_req = '0;
    dc_req = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!ic_pend && $urandom_range(0, 1) == 1) begin ic_req = rand_req(); ic_pend = 1; end
      if (!dc_pend && $urandom_range(0, 1) == 1) begin dc_req = rand_req(); dc_pend = 1; end
      bus.icache2mem_i = ic_pend ? ic_req : '0;
      bus.dcache2mem_i = dc_pend ? dc_req : '0;
      bus.mem2arb_i    = '{r_data: rand_line(), ack: ($urandom_range(0, 2) == 0)};
      @(negedge clk);
      exp_arb = '0; exp_i = '0; exp_d = '0; exp_busy = 1'b0;
      if (!rst) begin
        if (owner == 1) begin exp_arb = bus.icache2mem_i; exp_i = bus.mem2arb_i; end
        if (owner == 2) begin exp_arb = bus.dcache2mem_i; exp_d = bus.mem2arb_i; end
        exp_busy = (owner != 0) || gap;
      end
      checks++; if (bus.arb2mem_o !== exp_arb) begin failures++; $display("FAIL rnd_arb2mem_%0d got=%h exp=%h", cyc, bus.arb2mem_o, exp_arb); end
      checks++; if (bus.mem2icache_o !== exp_i) begin failures++; $display("FAIL rnd_mem2icache_%0d got=%h exp=%h", cyc, bus.mem2icache_o, exp_i); end
      checks++; if (bus.mem2dcache_o !== exp_d) begin failures++; $display("FAIL rnd_mem2dcache_%0d got=%h exp=%h", cyc, bus.mem2dcache_o, exp_d); end
      checks++; if (arb_busy_o !== exp_busy) begin failures++; $display("FAIL rnd_busy_%0d got=%b exp=%b", cyc, arb_busy_o, exp_busy); end
      if (bus.mem2icache_o.ack === 1'b1) ic_pend = 0;
      if (bus.mem2dcache_o.ack === 1'b1) dc_pend = 0;
      if (rst) begin
        owner = 0; gap = 0; served_last = 1;
      end else if (owner != 0) begin
        if (bus.mem2arb_i.ack) begin owner = 0; gap = 1; end
      end else if (gap) begin
        gap = 0;
      end else begin
        if (bus.icache2mem_i.req && bus.dcache2mem_i.req) owner = 3 - served_last;
        else if (bus.icache2mem_i.req) owner = 1;
        else if (bus.dcache2mem_i.req) owner = 2;
        if (owner != 0) served_last = owner;
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_icache_read();
    test_contention();
    test_back_to_back();
    test_dcache_write();
    test_reset_mid();
    test_spurious_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
